alu_pipe: RTL and testbench

//   Registered, parametrised successor to the combinational 4-op ALU. Adds
//   SUB and shift ops, carry-correct flags, and an internal accumulator.
//   Has a one-stage valid/ready pipeline so it sits directly between a

---
 rtl/alu_pipe.sv | 119 +++++++++++
 tb/tb_alu_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Registered W-bit ALU with NZCV flags, internal accumulator and a single
// valid/ready output stage that can absorb consumer backpressure.
module alu_pipe #(
    parameter int             W        = 4,
    parameter logic [W-1:0]   ACC_INIT = '0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_use_acc,
    input  logic          in_acc_we,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic          out_n,
    output logic          out_z,
    output logic          out_c,
    output logic          out_v,
    output logic [W-1:0]  acc
);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    logic          out_valid_reg;
    logic [W-1:0]  result_reg;
    logic          n_reg, z_reg, c_reg, v_reg;
    logic [W-1:0]  acc_reg;

    logic          accept;
    logic [W-1:0]  op_a;
    logic [W:0]    sum_add;
    logic [W:0]    sum_sub;
    logic [W-1:0]  result_next;
    logic          c_next;
    logic          v_next;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Accumulator is read before this edge's write-back, so chained ops see the previous result.
    assign op_a = in_use_acc ? acc_reg : in_a;

    assign sum_add = {1'b0, op_a} + {1'b0, in_b};
    assign sum_sub = {1'b0, op_a} + {1'b0, ~in_b} + {{W{1'b0}}, 1'b1};

    always_comb begin
        result_next = '0;
        c_next      = 1'b0;
        v_next      = 1'b0;
        case (in_op)
            OP_ADD: begin
                result_next = sum_add[W-1:0];
                c_next      = sum_add[W];
                v_next      = (op_a[W-1] == in_b[W-1]) && (sum_add[W-1] != op_a[W-1]);
            end
            OP_SUB: begin
                result_next = sum_sub[W-1:0];
                c_next      = sum_sub[W];
                v_next      = (op_a[W-1] != in_b[W-1]) && (sum_sub[W-1] != op_a[W-1]);
            end
            OP_AND:  result_next = op_a & in_b;
            OP_OR:   result_next = op_a | in_b;
            OP_XOR:  result_next = op_a ^ in_b;
            OP_SHL: begin
                result_next = {op_a[W-2:0], 1'b0};
                c_next      = op_a[W-1];
            end
            OP_SHR: begin
                result_next = {1'b0, op_a[W-1:1]};
                c_next      = op_a[0];
            end
            OP_PASSB: result_next = in_b;
            default:  result_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            n_reg         <= 1'b0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            acc_reg       <= ACC_INIT;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            result_reg    <= result_next;
            n_reg         <= result_next[W-1];
            z_reg         <= (result_next == '0);
            c_reg         <= c_next;
            v_reg         <= v_next;
            if (in_acc_we)
                acc_reg <= result_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = result_reg;
    assign out_n      = n_reg;
    assign out_z      = z_reg;
    assign out_c      = c_reg;
    assign out_v      = v_reg;
    assign acc        = acc_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (W=4, ACC_INIT=0) with hand-computed
// results, flags, handshake and accumulator expectations.
module tb_alu_pipe;

    localparam int W = 4;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_use_acc;
    logic          in_acc_we;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_n, out_z, out_c, out_v;
    logic [W-1:0]  acc;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.W(W), .ACC_INIT(4'b0000)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .in_acc_we  (in_acc_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_n      (out_n),
        .out_z      (out_z),
        .out_c      (out_c),
        .out_v      (out_v),
        .acc        (acc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic use_acc, input logic we);
        in_valid   = 1'b1;
        in_op      = op;
        in_a       = a;
        in_b       = b;
        in_use_acc = use_acc;
        in_acc_we  = we;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
        in_acc_we  = 1'b0;
    endtask

    function automatic logic [3:0] flags();
        return {out_n, out_z, out_c, out_v};
    endfunction

    // op, a, b, expected result, expected {N,Z,C,V}
    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic [3:0] nzcv;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'd0, 4'b0111, 4'b0001, 4'b1000, 4'b1001}; // ADD signed overflow
        vecs[1] = '{3'd1, 4'b0011, 4'b0011, 4'b0000, 4'b0110}; // SUB equal
        vecs[2] = '{3'd1, 4'b0010, 4'b0101, 4'b1101, 4'b1000}; // SUB borrow
        vecs[3] = '{3'd6, 4'b0101, 4'b0000, 4'b0010, 4'b0010}; // SHR
        vecs[4] = '{3'd5, 4'b1001, 4'b0000, 4'b0010, 4'b0010}; // SHL
        vecs[5] = '{3'd4, 4'b1100, 4'b1010, 4'b0110, 4'b0000}; // XOR
        vecs[6] = '{3'd2, 4'b1100, 4'b1010, 4'b1000, 4'b1000}; // AND
        vecs[7] = '{3'd3, 4'b0100, 4'b0010, 4'b0110, 4'b0000}; // OR
        vecs[8] = '{3'd7, 4'b0011, 4'b1111, 4'b1111, 4'b1000}; // PASSB
        vecs[9] = '{3'd1, 4'b1000, 4'b0001, 4'b0111, 4'b0011}; // SUB signed overflow

        reset = 1'b1; out_ready = 1'b0;
        in_op = 3'd0; in_a = '0; in_b = '0;
        idle();
        step(); step();
        reset = 1'b0;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_result", 32'(out_result), 32'd0);
        check_val("rst_flags", 32'(flags()), 32'd0);
        check_val("rst_acc", 32'(acc), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);

        // Single ADD, then one idle cycle drains the output.
        out_ready = 1'b1;
        drive(3'd0, 4'b0111, 4'b0001, 1'b0, 1'b0);
        step();
        idle();
        check_val("add_valid", 32'(out_valid), 32'd1);
        check_val("add_result", 32'(out_result), 32'b1000);
        check_val("add_flags", 32'(flags()), 32'b1001);
        step();
        check_val("idle_valid", 32'(out_valid), 32'd0);

        // Full-throughput table, one op per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            step();
            check_val($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check_val($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].r));
            check_val($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].nzcv));
        end
        idle();
        step();
        check_val("acc_untouched", 32'(acc), 32'd0);

        // Backpressure: result held, queued op waits until out_ready rises.
        out_ready = 1'b0;
        drive(3'd0, 4'b0001, 4'b0001, 1'b0, 1'b0);
        step();
        drive(3'd0, 4'b0011, 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            check_val($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            check_val($sformatf("bp%0d_result", i), 32'(out_result), 32'b0010);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        idle();
        check_val("bp_queued_valid", 32'(out_valid), 32'd1);
        check_val("bp_queued_result", 32'(out_result), 32'b0111);
        step();
        check_val("bp_drain_valid", 32'(out_valid), 32'd0);

        // Back-to-back accumulate chain.
        begin
            logic [3:0] exp_r[4];
            logic [3:0] exp_f[4];
            exp_r[0] = 4'b0101; exp_f[0] = 4'b0000;
            exp_r[1] = 4'b1010; exp_f[1] = 4'b1001;
            exp_r[2] = 4'b1111; exp_f[2] = 4'b1000;
            exp_r[3] = 4'b0100; exp_f[3] = 4'b0010;
            for (int i = 0; i < 4; i++) begin
                drive(3'd0, 4'b1111, 4'b0101, 1'b1, 1'b1);
                step();
                check_val($sformatf("accum%0d_result", i), 32'(out_result), 32'(exp_r[i]));
                check_val($sformatf("accum%0d_flags", i), 32'(flags()), 32'(exp_f[i]));
                check_val($sformatf("accum%0d_acc", i), 32'(acc), 32'(exp_r[i]));
            end
        end

        // Reading acc without writing it leaves it unchanged.
        drive(3'd0, 4'b0000, 4'b0001, 1'b1, 1'b0);
        step();
        check_val("useacc_nowe_result", 32'(out_result), 32'b0101);
        check_val("useacc_nowe_acc", 32'(acc), 32'b0100);

        // Reset while a result is stalled.
        drive(3'd7, 4'b0000, 4'b1010, 1'b0, 1'b1);
        step();
        idle();
        out_ready = 1'b0;
        step();
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        check_val("pre_rst_acc", 32'(acc), 32'b1010);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_result", 32'(out_result), 32'd0);
        check_val("midrst_flags", 32'(flags()), 32'd0);
        check_val("midrst_acc", 32'(acc), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
